cbsc_mac_seq: RTL and testbench

//  Sequencer for one comparator-based stochastic-computing dot product.
//  For each of vec_len elements it fetches a weight and loads the weight down-counter (cnt_rst/cnt_w).
//  It enables the bitstream accumulator until the counter raises cnt_stop, then advances to the next element.
//  It sits between the MAC top-level control and the counter/accumulator datapath.

---
 rtl/cbsc_pkg.sv | 27 ++
 rtl/cbsc_mac_seq_if.sv | 40 ++++
 rtl/cbsc_mac_seq.sv | 112 +++++++++++
 tb/tb_cbsc_mac_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbsc_pkg.sv
// Shared definitions for the comparator-based stochastic-computing MAC sequencer.
//   CBSC_W_W     : weight width; equals the down-counter init width
//   CBSC_LEN_W   : width of vec_len, the element index and w_addr
//   CBSC_TMO_CYC : RUN cycles allowed per element before err (2**W_W+2)
//   seq_state_t  : sequencer state encoding
package cbsc_pkg;

  localparam int CBSC_W_W     = 8;
  localparam int CBSC_LEN_W   = 8;
  localparam int CBSC_TMO_CYC = 258;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_NEXT,
    S_DONE
  } seq_state_t;

  // Width of a counter that must hold 0..cyc-1.
  function automatic int tmo_width(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/cbsc_mac_seq_if.sv
// Bundle of the sequencer's control, weight-fetch and datapath signals.
//   master : the sequencer (cbsc_mac_seq)
//   slave  : the surroundings (MAC control, weight store, counter, accumulator)
//   start/vec_len/busy/done/err : MAC top-level control
//   w_req/w_addr/w_vld/w_data   : weight fetch handshake (w_req && w_vld)
//   cnt_rst/cnt_w/cnt_stop      : down-counter load and stop level
//   acc_clr/acc_en              : bitstream accumulator clear/enable
interface cbsc_mac_seq_if
  import cbsc_pkg::*;
#(
  parameter int W_W   = CBSC_W_W,
  parameter int LEN_W = CBSC_LEN_W
) ();

  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             busy;
  logic             done;
  logic             err;
  logic             w_req;
  logic [LEN_W-1:0] w_addr;
  logic             w_vld;
  logic [W_W-1:0]   w_data;
  logic             cnt_rst;
  logic [W_W-1:0]   cnt_w;
  logic             cnt_stop;
  logic             acc_clr;
  logic             acc_en;

  modport master (
    input  start, vec_len, w_vld, w_data, cnt_stop,
    output busy, done, err, w_req, w_addr, cnt_rst, cnt_w, acc_clr, acc_en
  );

  modport slave (
    output start, vec_len, w_vld, w_data, cnt_stop,
    input  busy, done, err, w_req, w_addr, cnt_rst, cnt_w, acc_clr, acc_en
  );

endinterface

// File: rtl/cbsc_mac_seq.sv
// Sequencer for one comparator-based stochastic-computing dot product.
// For each element: fetch the weight, load the down-counter, then enable the
// bitstream accumulator until the counter raises cnt_stop.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : cbsc_mac_seq_if.master (control, weight fetch, counter, accumulator)
module cbsc_mac_seq
  import cbsc_pkg::*;
#(
  parameter int W_W     = CBSC_W_W,
  parameter int LEN_W   = CBSC_LEN_W,
  parameter int TMO_CYC = CBSC_TMO_CYC
) (
  input  logic             clk,
  input  logic             rst,
  cbsc_mac_seq_if.master   bus
);

  localparam int               TMO_W    = tmo_width(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [W_W-1:0]   wreg_q, wreg_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             acc_clr_q, acc_clr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      wreg_q    <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wreg_q    <= wreg_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      acc_clr_q <= acc_clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wreg_d    = wreg_q;
    tmo_d     = '0;       // only RUN keeps counting
    err_d     = err_q;
    acc_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d     = bus.vec_len;
          idx_d     = '0;
          err_d     = 1'b0;
          acc_clr_d = 1'b1;
          state_d   = (bus.vec_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.w_vld) begin
          wreg_d  = bus.w_data;
          // A zero weight contributes no bit-cycles, so skip the counter.
          state_d = (bus.w_data == '0) ? S_NEXT : S_LOAD;
        end
      end
      S_LOAD:   state_d = S_SETTLE;
      // cnt_stop still reflects the previous element here; one blind cycle.
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (bus.cnt_stop) begin
          state_d = S_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q == LEN_W'(len_q - 1'b1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.err     = err_q;
  assign bus.w_req   = (state_q == S_FETCH);
  assign bus.w_addr  = idx_q;
  assign bus.cnt_rst = (state_q == S_LOAD);
  assign bus.cnt_w   = wreg_q;
  assign bus.acc_clr = acc_clr_q;
  // The counter drops cnt_stop mid-cycle; the accumulator samples the settled level.
  assign bus.acc_en  = (state_q == S_SETTLE) || ((state_q == S_RUN) && !bus.cnt_stop);

endmodule

// File: tb/tb_cbsc_mac_seq.sv
// Directed bench for cbsc_mac_seq with a behavioural down-counter and weight responder.
module tb_cbsc_mac_seq;
  import cbsc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cbsc_mac_seq_if bus ();

  cbsc_mac_seq #(.W_W(8), .LEN_W(8), .TMO_CYC(258)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Down-counter: load on cnt_rst, decrement while stop low, stop on negedge.
  logic [7:0] mcnt      = 8'd0;
  logic       stop_tie0 = 1'b0;
  always @(posedge clk) begin
    if (bus.cnt_rst) mcnt <= bus.cnt_w;
    else if (!bus.cnt_stop && mcnt != 8'd0) mcnt <= mcnt - 8'd1;
  end
  always @(negedge clk) bus.cnt_stop <= stop_tie0 ? 1'b0 : (mcnt == 8'd0);

  // Weight store: answers after dly cycles of w_req, checks w_addr stability.
  logic [7:0] wtab [0:3];
  int         dly = 1;
  int         wcnt = 0;
  int         addr_viol = 0;
  logic [7:0] addr0;
  always begin
    @(posedge clk);
    #1;
    if (bus.w_req) begin
      if (wcnt == 0) addr0 = bus.w_addr;
      else if (bus.w_addr !== addr0) addr_viol++;
      if (wcnt >= dly) begin
        bus.w_vld  = 1'b1;
        bus.w_data = wtab[bus.w_addr[1:0]];
      end else begin
        bus.w_vld = 1'b0;
      end
      wcnt++;
    end else begin
      bus.w_vld = 1'b0;
      wcnt = 0;
    end
  end

  // Event monitor, sampled mid-cycle after cnt_stop settles.
  int         n_acc = 0, n_rst = 0, n_done = 0, n_req = 0, n_clr = 0;
  int         err_at_done = -1;
  logic [7:0] cw_q [$];
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (bus.acc_en)  n_acc++;
      if (bus.cnt_rst) begin n_rst++; cw_q.push_back(bus.cnt_w); end
      if (bus.done)    begin n_done++; err_at_done = int'(bus.err); end
      if (bus.w_req)   n_req++;
      if (bus.acc_clr) n_clr++;
    end
  end

  task automatic clr_mon();
    n_acc = 0; n_rst = 0; n_done = 0; n_req = 0; n_clr = 0;
    err_at_done = -1;
    cw_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int len);
    bus.start   = 1'b1;
    bus.vec_len = 8'(len);
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!bus.done && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, int'(bus.done), 1);
    tick();
    tick();
  endtask

  function automatic int outs();
    return int'({bus.busy, bus.done, bus.err, bus.w_req, bus.w_addr,
                 bus.cnt_rst, bus.cnt_w, bus.acc_clr, bus.acc_en});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.vec_len = 8'd0;
    for (int i = 0; i < 4; i++) wtab[i] = 8'd0;

    // T1: reset held 3 cycles with start asserted
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.vec_len = 8'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t1_outs_c%0d", i), outs(), 0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("t1_busy_after_rst", int'(bus.busy), 0);
    chk("t1_outs_after_rst", outs(), 0);

    // T2: three elements {3,1,5}
    wtab[0] = 8'd3; wtab[1] = 8'd1; wtab[2] = 8'd5;
    dly = 1;
    clr_mon();
    kick(3);
    chk("t2_busy", int'(bus.busy), 1);
    chk("t2_acc_clr", int'(bus.acc_clr), 1);
    wait_done(200, "t2");
    chk("t2_n_cnt_rst", n_rst, 3);
    chk("t2_cw_len", cw_q.size(), 3);
    if (cw_q.size() == 3) begin
      chk("t2_cw0", int'(cw_q[0]), 3);
      chk("t2_cw1", int'(cw_q[1]), 1);
      chk("t2_cw2", int'(cw_q[2]), 5);
    end
    chk("t2_acc_en", n_acc, 9);
    chk("t2_n_done", n_done, 1);
    chk("t2_err", err_at_done, 0);
    chk("t2_n_clr", n_clr, 1);
    chk("t2_idle", int'(bus.busy), 0);

    // T3: empty vector
    clr_mon();
    kick(0);
    chk("t3_acc_clr", int'(bus.acc_clr), 1);
    chk("t3_done", int'(bus.done), 1);
    tick();
    tick();
    chk("t3_n_req", n_req, 0);
    chk("t3_n_cnt_rst", n_rst, 0);
    chk("t3_acc_en", n_acc, 0);
    chk("t3_n_done", n_done, 1);
    chk("t3_n_clr", n_clr, 1);
    chk("t3_idle", int'(bus.busy), 0);

    // T4: weights {0,2}, slow fetch, stray start mid-run
    wtab[0] = 8'd0; wtab[1] = 8'd2;
    dly = 4;
    clr_mon();
    addr_viol = 0;
    kick(2);
    repeat (3) tick();
    bus.start   = 1'b1;
    bus.vec_len = 8'd5;
    tick();
    bus.start   = 1'b0;
    chk("t4_busy_mid", int'(bus.busy), 1);
    wait_done(200, "t4");
    chk("t4_n_cnt_rst", n_rst, 1);
    if (cw_q.size() == 1) chk("t4_cw0", int'(cw_q[0]), 2);
    else chk("t4_cw_len", cw_q.size(), 1);
    chk("t4_acc_en", n_acc, 2);
    chk("t4_n_done", n_done, 1);
    chk("t4_addr_stable", addr_viol, 0);
    chk("t4_n_req", n_req, 10);
    repeat (5) tick();
    chk("t4_idle", int'(bus.busy), 0);

    // T5: counter never stops -> timeout
    stop_tie0 = 1'b1;
    wtab[0] = 8'd7;
    dly = 1;
    clr_mon();
    kick(1);
    wait_done(400, "t5");
    chk("t5_err_at_done", err_at_done, 1);
    chk("t5_acc_en", n_acc, 259);
    chk("t5_n_done", n_done, 1);
    chk("t5_n_cnt_rst", n_rst, 1);
    chk("t5_err_sticky", int'(bus.err), 1);
    stop_tie0 = 1'b0;
    tick();
    kick(0);
    chk("t5_err_cleared", int'(bus.err), 0);
    tick();
    tick();

    // T6: reset during RUN of element 1
    wtab[0] = 8'd2; wtab[1] = 8'd6; wtab[2] = 8'd3;
    dly = 1;
    clr_mon();
    kick(3);
    begin
      int k = 0;
      while (!(bus.cnt_rst && bus.w_addr == 8'd1) && k < 100) begin
        tick();
        k++;
      end
    end
    chk("t6_reach_load1", int'(bus.cnt_rst && bus.w_addr == 8'd1), 1);
    tick();
    tick();
    chk("t6_in_run_acc_en", int'(bus.acc_en), 1);
    rst = 1'b1;
    tick();
    chk("t6_outs_after_rst", outs(), 0);
    rst = 1'b0;
    wtab[0] = 8'd4;
    clr_mon();
    kick(1);
    wait_done(200, "t6");
    chk("t6_acc_en", n_acc, 4);
    chk("t6_n_done", n_done, 1);
    chk("t6_n_cnt_rst", n_rst, 1);
    if (cw_q.size() == 1) chk("t6_cw0", int'(cw_q[0]), 4);
    else chk("t6_cw_len", cw_q.size(), 1);
    chk("t6_err", err_at_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
